// File: rtl/coded_event_counter_pkg.sv
// Encoding helpers and next-count logic shared by coded_event_counter.
// Helpers work on the widest supported sizes; callers widen and truncate.
package coded_event_counter_pkg;

  localparam int CNT_W_MAX = 16;
  localparam int FILT_MAX  = 7;
  localparam int OH_W_MAX  = 64;

  typedef enum logic {
    CNT_DN = 1'b0,
    CNT_UP = 1'b1
  } cnt_dir_e;

  typedef struct packed {
    logic [CNT_W_MAX-1:0] val;
    logic                 wrap;
  } cnt_next_t;

  function automatic logic maj_func(
    input logic [FILT_MAX-1:0] v,
    input int                  n
  );
    int ones;
    ones = 0;
    for (int i = 0; i < FILT_MAX; i++) begin
      if (i < n && v[i]) ones++;
    end
    return (2 * ones > n);
  endfunction

  function automatic logic [CNT_W_MAX-1:0] bin2grey(
    input logic [CNT_W_MAX-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [OH_W_MAX-1:0] bin2onehot(
    input logic [5:0] b
  );
    return OH_W_MAX'(1) << b;
  endfunction

  function automatic cnt_next_t next_count(
    input logic [CNT_W_MAX-1:0] bin,
    input cnt_dir_e             dir,
    input logic [CNT_W_MAX-1:0] max,
    input logic                 saturate
  );
    cnt_next_t r;
    r.val  = bin;
    r.wrap = 1'b0;
    if (dir == CNT_UP) begin
      if (bin < max) begin
        r.val = bin + 1'b1;
      end else if (!saturate) begin
        r.val  = '0;
        r.wrap = 1'b1;
      end
    end else begin
      if (bin != '0) begin
        r.val = bin - 1'b1;
      end else if (!saturate) begin
        r.val  = max;
        r.wrap = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/coded_event_counter_filter.sv
// FILT-sample majority filter with rising-edge detect on the filtered level.
module maj_edge_filter
  import coded_event_counter_pkg::*;
#(
  parameter int FILT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_en,
  input  logic evt_in,
  output logic step
);

  logic [FILT-1:0]     r_hist;
  logic                r_filt_q;
  logic [FILT_MAX-1:0] w_hist_x;
  logic                w_filt;

  if ((FILT % 2) == 0 || FILT < 1 || FILT > FILT_MAX) begin : g_bad_filt
    $error("FILT must be odd and in 1..7");
  end

  assign w_hist_x = FILT_MAX'(r_hist);
  assign w_filt   = maj_func(w_hist_x, FILT);
  assign step     = w_filt & ~r_filt_q;

  // Newest sample enters at bit 0; majority is order-independent.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hist   <= '0;
      r_filt_q <= 1'b0;
    end else if (clk_en) begin
      r_hist   <= FILT'({r_hist, evt_in});
      r_filt_q <= w_filt;
    end
  end

endmodule

// File: rtl/coded_event_counter.sv
// Filtered up/down event counter with coherent binary/Gray views.
// Define CODED_CNT_ONEHOT_EN to add the registered one-hot view.
module coded_event_counter
  import coded_event_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX      = (1 << WIDTH) - 1,
  parameter int FILT     = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             evt_in,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt_bin,
  output logic [WIDTH-1:0] cnt_gray,
`ifdef CODED_CNT_ONEHOT_EN
  output logic [MAX:0]     cnt_onehot,
`endif
  output logic             wrap,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [CNT_W_MAX-1:0] MAX_X =
    CNT_W_MAX'(MAX);

  if (WIDTH < 1 || WIDTH > CNT_W_MAX) begin : g_bad_w
    $error("WIDTH must be in 1..16");
  end
  if (MAX < 1 || MAX > (1 << WIDTH) - 1) begin : g_bad_max
    $error("MAX must be in 1..2^WIDTH-1");
  end

  logic [WIDTH-1:0]     r_bin;
  logic [WIDTH-1:0]     r_gray;
  logic                 r_wrap;
  logic                 r_at_max;
  logic                 r_at_min;
  logic                 w_step;
  logic [CNT_W_MAX-1:0] w_bin_x;
  logic [CNT_W_MAX-1:0] w_ld_x;
  logic [CNT_W_MAX-1:0] w_next_x;
  logic [CNT_W_MAX-1:0] w_gray_x;
  logic                 w_next_wrap;
  cnt_next_t            w_nc;
  logic                 w_unused;

  maj_edge_filter #(
    .FILT(FILT)
  ) u_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .clk_en(clk_en),
    .evt_in(evt_in),
    .step  (w_step)
  );

  assign w_bin_x  = CNT_W_MAX'(r_bin);
  assign w_ld_x   = CNT_W_MAX'(load_val);
  assign w_nc     = next_count(w_bin_x, cnt_dir_e'(dir),
                               MAX_X, SATURATE);
  assign w_gray_x = bin2grey(w_next_x);

  // A load consumes the filtered edge of the same cycle.
  always_comb begin
    w_next_x    = w_bin_x;
    w_next_wrap = 1'b0;
    if (load) begin
      w_next_x = (w_ld_x > MAX_X) ? MAX_X : w_ld_x;
    end else if (w_step) begin
      w_next_x    = w_nc.val;
      w_next_wrap = w_nc.wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bin    <= '0;
      r_gray   <= '0;
      r_wrap   <= 1'b0;
      r_at_max <= 1'b0;
      r_at_min <= 1'b1;
    end else if (clk_en) begin
      r_bin    <= w_next_x[WIDTH-1:0];
      r_gray   <= w_gray_x[WIDTH-1:0];
      r_wrap   <= w_next_wrap;
      r_at_max <= (w_next_x == MAX_X);
      r_at_min <= (w_next_x == '0);
    end else begin
      r_wrap   <= 1'b0;
    end
  end

  assign cnt_bin  = r_bin;
  assign cnt_gray = r_gray;
  assign wrap     = r_wrap;
  assign at_max   = r_at_max;
  assign at_min   = r_at_min;

`ifdef CODED_CNT_ONEHOT_EN
  localparam logic [MAX:0] OH_ONE = 1;

  if (WIDTH > 6) begin : g_bad_oh
    $error("one-hot view needs WIDTH <= 6");
  end

  logic [MAX:0]          r_onehot;
  logic [OH_W_MAX-1:0]   w_oh_x;

  assign w_oh_x = bin2onehot(w_next_x[5:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_onehot <= OH_ONE;
    end else if (clk_en) begin
      r_onehot <= w_oh_x[MAX:0];
    end
  end

  assign cnt_onehot = r_onehot;
  assign w_unused   = ^{w_gray_x, w_nc, w_oh_x};
`else
  assign w_unused   = ^{w_gray_x, w_nc};
`endif

endmodule

// File: tb/tb_coded_event_counter.sv
// Scoreboarded bench: u0 default (MAX=15, wrap), u1 MAX=9 saturating.
module tb_coded_event_counter;

  typedef logic [26:0] word_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b0;
  logic       evt_in = 1'b0;
  logic       dir = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] b0, g0, b1, g1;
  logic       w0, mx0, mn0, w1, mx1, mn1;
`ifdef CODED_CNT_ONEHOT_EN
  logic [15:0] oh0;
  logic [9:0]  oh1;
`endif

  word_t q_exp[$];
  word_t q_obs[$];
  int    n_chk = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  coded_event_counter #(
    .WIDTH(4)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .evt_in(evt_in), .dir(dir), .load(load),
    .load_val(load_val),
    .cnt_bin(b0), .cnt_gray(g0),
`ifdef CODED_CNT_ONEHOT_EN
    .cnt_onehot(oh0),
`endif
    .wrap(w0), .at_max(mx0), .at_min(mn0)
  );

  coded_event_counter #(
    .WIDTH(4), .MAX(9), .FILT(3), .SATURATE(1'b1)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .evt_in(evt_in), .dir(dir), .load(load),
    .load_val(load_val),
    .cnt_bin(b1), .cnt_gray(g1),
`ifdef CODED_CNT_ONEHOT_EN
    .cnt_onehot(oh1),
`endif
    .wrap(w1), .at_max(mx1), .at_min(mn1)
  );

  function automatic word_t exp_of(int b, bit w, int mx);
    logic [15:0] oh;
    logic [3:0]  bb;
    bb = b[3:0];
    oh = '0;
`ifdef CODED_CNT_ONEHOT_EN
    oh = 16'(1) << bb;
`endif
    return {oh, bb, bb ^ (bb >> 1), w, b == mx, b == 0};
  endfunction

  function automatic word_t obs_of(bit sel);
    logic [15:0] oh;
    oh = '0;
`ifdef CODED_CNT_ONEHOT_EN
    oh = sel ? 16'(oh1) : oh0;
`endif
    if (sel) return {oh, b1, g1, w1, mx1, mn1};
    return {oh, b0, g0, w0, mx0, mn0};
  endfunction

  task automatic stim(input bit sel, input bit rs, input bit en,
                      input bit ev, input bit d, input bit ld,
                      input int lv, input int eb, input bit ew);
    rst_n    = rs;
    clk_en   = en;
    evt_in   = ev;
    dir      = d;
    load     = ld;
    load_val = lv[3:0];
    q_exp.push_back(exp_of(eb, ew, sel ? 9 : 15));
    @(posedge clk);
    #1;
    q_obs.push_back(obs_of(sel));
  endtask

  task automatic test_reset();
    word_t e, o;
    int i = 0;
    stim(0, 0, 0, 0, 1, 0, 0, 0, 0);
    stim(0, 0, 0, 1, 1, 0, 0, 0, 0);
    stim(1, 0, 0, 0, 1, 0, 0, 0, 0);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      o = q_obs.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %h expected %h", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_held();
    word_t e, o;
    int i = 0;
    for (int k = 0; k < 6; k++)
      stim(0, 1, 1, 1, 1, 0, 0, (k < 2) ? 0 : 1, 0);
    for (int k = 0; k < 3; k++)
      stim(0, 1, 1, 0, 1, 0, 0, 1, 0);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      o = q_obs.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL held[%0d]: got %h expected %h", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_glitch();
    word_t e, o;
    int i = 0;
    for (int k = 0; k < 5; k++)
      stim(0, 1, 1, k == 0, 1, 0, 0, 1, 0);
    for (int k = 0; k < 6; k++)
      stim(0, 1, 1, k < 2, 1, 0, 0, (k < 2) ? 1 : 2, 0);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      o = q_obs.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL glitch[%0d]: got %h expected %h", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_wrap();
    word_t e, o;
    int i = 0;
    stim(0, 1, 1, 0, 1, 1, 15, 15, 0);
    for (int k = 0; k < 6; k++)
      stim(0, 1, 1, k < 2, 1, 0, 0, (k < 2) ? 15 : 0, k == 2);
    for (int k = 0; k < 6; k++)
      stim(0, 1, 1, k < 2, 0, 0, 0, (k < 2) ? 0 : 15, k == 2);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      o = q_obs.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got %h expected %h", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_load_step();
    word_t e, o;
    int i = 0;
    stim(0, 1, 1, 0, 1, 1, 3, 3, 0);
    stim(0, 1, 1, 1, 1, 0, 0, 3, 0);
    stim(0, 1, 1, 1, 1, 0, 0, 3, 0);
    stim(0, 1, 1, 0, 1, 1, 5, 5, 0);
    for (int k = 0; k < 3; k++)
      stim(0, 1, 1, 0, 1, 0, 0, 5, 0);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      o = q_obs.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL load_step[%0d]: got %h expected %h", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_clk_en();
    word_t e, o;
    int i = 0;
    stim(0, 1, 1, 1, 1, 0, 0, 5, 0);
    stim(0, 1, 1, 1, 1, 0, 0, 5, 0);
    for (int k = 0; k < 4; k++)
      stim(0, 1, 0, 1, 1, 0, 0, 5, 0);
    stim(0, 1, 1, 1, 1, 0, 0, 6, 0);
    for (int k = 0; k < 3; k++)
      stim(0, 1, 1, 0, 1, 0, 0, 6, 0);
    stim(0, 1, 1, 0, 1, 1, 15, 15, 0);
    stim(0, 1, 1, 1, 1, 0, 0, 15, 0);
    stim(0, 1, 1, 1, 1, 0, 0, 15, 0);
    stim(0, 1, 1, 0, 1, 0, 0, 0, 1);
    stim(0, 1, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      stim(0, 1, 1, 0, 1, 0, 0, 0, 0);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      o = q_obs.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL clk_en[%0d]: got %h expected %h", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_saturate();
    word_t e, o;
    int i = 0;
    stim(1, 1, 1, 0, 1, 1, 12, 9, 0);
    for (int k = 0; k < 6; k++)
      stim(1, 1, 1, k < 2, 1, 0, 0, 9, 0);
    for (int k = 0; k < 6; k++)
      stim(1, 1, 1, k < 2, 0, 0, 0, (k < 2) ? 9 : 8, 0);
    stim(1, 1, 1, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 6; k++)
      stim(1, 1, 1, k < 2, 0, 0, 0, 0, 0);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      o = q_obs.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL saturate[%0d]: got %h expected %h", i, o, e);
      end
      i++;
    end
  endtask

  task automatic test_reset_mid();
    word_t e, o;
    int i = 0;
    stim(0, 1, 1, 0, 1, 1, 5, 5, 0);
    stim(0, 1, 1, 1, 1, 0, 0, 5, 0);
    stim(0, 0, 1, 1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      stim(0, 1, 1, 1, 1, 0, 0, (k < 2) ? 0 : 1, 0);
    for (int k = 0; k < 3; k++)
      stim(0, 1, 1, 0, 1, 0, 0, 1, 0);
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      o = q_obs.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: got %h expected %h", i, o, e);
      end
      i++;
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_held();
    test_glitch();
    test_wrap();
    test_load_step();
    test_clk_en();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
